alu_shift_seq: RTL and testbench

Parametrised, sequential successor to the combinational ALU logical-shift-right unit. It accepts an operand, shift amount and shift mode through a valid/ready handshake. It shifts iteratively, one bit position per clock, and holds the result, carry-out and zero flag until the consumer accepts them. It sits beside the other ALU units and is used where a shift does not need single-cycle latency.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_shift_step.sv | 39 +++
 rtl/alu_shift_seq.sv | 105 ++++++++++
 tb/tb_alu_shift_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-mode and sequential-shifter state encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSR = 2'b00,
    SHIFT_LSL = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// One-position shifter: moves value by a single bit according to mode and
// reports the bit that falls off the end.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  shift_mode_t      mode_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o
);

  // NOTE: both outputs get a default before the case so no latch is inferred.
  always_comb begin
    value_o = value_i;
    carry_o = 1'b0;
    case (mode_i)
      SHIFT_LSR: begin
        value_o = {1'b0, value_i[WIDTH-1:1]};
        carry_o = value_i[0];
      end
      SHIFT_LSL: begin
        value_o = {value_i[WIDTH-2:0], 1'b0};
        carry_o = value_i[WIDTH-1];
      end
      SHIFT_ASR: begin
        value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        carry_o = value_i[0];
      end
      SHIFT_ROR: begin
        value_o = {value_i[0], value_i[WIDTH-1:1]};
        carry_o = value_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative shifter: accepts a request, shifts one bit per clock, then holds
// dout/carry/zero until the consumer takes them.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [AMT_W-1:0] immediate_offset,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             zero
);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  shift_mode_t      mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (acc_q),
    .mode_i  (mode_q),
    .value_o (step_value),
    .carry_o (step_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = operand1;
          cnt_d   = immediate_offset;
          mode_d  = shift_mode_t'(mode);
          carry_d = 1'b0;
          if (immediate_offset == '0) begin
            state_d = ST_DONE;
            zero_d  = (operand1 == '0);
          end else begin
            state_d = ST_SHIFT;
            zero_d  = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        acc_d   = step_value;
        carry_d = step_carry;
        cnt_d   = cnt_q - 1'b1;
        // zero is registered alongside the final shift so it is valid with out_valid.
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
          zero_d  = (step_value == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= SHIFT_LSR;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dout      = acc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed and randomised checks of alu_shift_seq against hand values and a
// closed-form shift model.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand1;
  logic [3:0]  immediate_offset;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        carry;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .operand1         (operand1),
    .immediate_offset (immediate_offset),
    .mode             (mode),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .dout             (dout),
    .carry            (carry),
    .zero             (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Closed-form reference, independent of the one-bit-per-cycle structure.
  task automatic ref_model(input logic [15:0] op, input int n, input logic [1:0] md,
                           output logic [15:0] r, output logic c);
    logic signed [15:0] s;
    s = op;
    c = (n == 0) ? 1'b0 : op[n-1];
    case (md)
      2'b00: r = op >> n;
      2'b01: begin
        r = op << n;
        c = (n == 0) ? 1'b0 : op[16-n];
      end
      2'b10: r = s >>> n;
      default: r = (n == 0) ? op : ((op >> n) | (op << (16 - n)));
    endcase
  endtask

  // Issues one request, measures latency, optionally stalls the consumer
  // (pulsing in_valid with foreign data meanwhile), then retires the result.
  task automatic do_op(input string tag, input logic [15:0] op, input int n,
                       input logic [1:0] md, input int stall, input bit pulse_in,
                       input logic [15:0] exp_dout, input logic exp_carry);
    int lat;
    bit busy_bad;
    bit hold_bad;
    check({tag, "_rdy_before"}, 32'(in_ready), 32'd1);
    operand1         = op;
    immediate_offset = 4'(n);
    mode             = md;
    in_valid         = 1'b1;
    out_ready        = (stall == 0);
    @(posedge clk); #1;
    in_valid         = 1'b0;
    operand1         = ~op;
    immediate_offset = 4'(15 - n);
    mode             = ~md;
    lat      = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    // out_valid rises on the n-th edge after the accepting edge; for n==0 it
    // is already up right after the accepting edge.
    check({tag, "_latency"}, 32'(lat), 32'(n));
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    check({tag, "_carry"}, 32'(carry), 32'(exp_carry));
    check({tag, "_zero"}, 32'(zero), 32'(exp_dout == 16'h0));
    hold_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (pulse_in) begin
        in_valid = i[0];
        operand1 = 16'hAAAA;
        immediate_offset = 4'd3;
      end
      @(posedge clk); #1;
      if (!out_valid || in_ready || dout !== exp_dout || carry !== exp_carry) hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    if (stall > 0) check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_nothing_queued"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] r_op, r_exp;
    logic        r_c;
    int          r_n;
    logic [1:0]  r_md;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand1 = '0; immediate_offset = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("lsr4",    16'hB6AD, 4,  2'b00, 0, 1'b0, 16'h0B6A, 1'b1);
    do_op("asr15",   16'h8001, 15, 2'b10, 0, 1'b0, 16'hFFFF, 1'b0);
    do_op("lsl1",    16'h8000, 1,  2'b01, 0, 1'b0, 16'h0000, 1'b1);
    do_op("ror1",    16'h0001, 1,  2'b11, 0, 1'b0, 16'h8000, 1'b1);
    do_op("ror0",    16'h1234, 0,  2'b11, 0, 1'b0, 16'h1234, 1'b0);
    do_op("bp_lsl8", 16'h00FF, 8,  2'b01, 5, 1'b1, 16'hFF00, 1'b0);

    // Reset after three shift cycles of a 10-bit LSR.
    operand1 = 16'hFFFF; immediate_offset = 4'd10; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    do_op("after_rst", 16'h0F00, 8, 2'b00, 0, 1'b0, 16'h000F, 1'b0);

    for (int k = 0; k < 200; k++) begin
      r_op = 16'($urandom);
      r_n  = int'($urandom_range(0, 15));
      r_md = 2'($urandom_range(0, 3));
      ref_model(r_op, r_n, r_md, r_exp, r_c);
      do_op($sformatf("rnd%0d", k), r_op, r_n, r_md, int'($urandom_range(0, 3)),
            1'b1, r_exp, r_c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
